// File: rtl/het_pkg.sv
// Shared types and constants for the heterodyne mixer/decimator.
// Sample, product and accumulator widths live here.
package het_pkg;
   localparam int ADC_W = 14;
   localparam int LO_W = 16;
   localparam int OUT_W = ADC_W + LO_W - 6;
   localparam int PROD_W = 30;
   localparam int ACC_W = 38;
   localparam int DEC_LOG2_MAX = 8;
   localparam int FIFO_DEPTH = 4;

   typedef logic signed [ADC_W-1:0] sample_t;
   typedef logic signed [LO_W-1:0] lo_t;
   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [OUT_W-1:0] out_t;

   typedef struct packed {
      logic v;
      logic first;
      logic last;
      logic [3:0] k;
   } tag_t;

   function automatic logic [3:0] clamp_k(input logic [3:0] k);
      return (k > 4'(DEC_LOG2_MAX)) ? 4'(DEC_LOG2_MAX) : k;
   endfunction
endpackage

// File: rtl/het_mixer_decim_if.sv
// Sample inputs and result stream of the mixer/decimator.
// The slave side is the mixer, the master side feeds and drains it.
interface het_mixer_decim_if;
   import het_pkg::*;

   logic adc_valid;
   sample_t adc_data;
   logic lo_valid;
   lo_t lo_data;
   out_t out_data;
   logic out_valid;
   logic out_ready;

   modport master (
      output adc_valid, adc_data, lo_valid, lo_data, out_ready,
      input out_data, out_valid
   );

   modport slave (
      input adc_valid, adc_data, lo_valid, lo_data, out_ready,
      output out_data, out_valid
   );
endinterface

// File: rtl/het_fifo.sv
// Small synchronous FIFO with a registered head output.
// A push into a full FIFO succeeds when a pop happens on the same edge.
module het_fifo #(
   parameter int W = 24,
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic push,
   input  logic [W-1:0] din,
   input  logic pop,
   output logic [W-1:0] dout,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] rd, wr, rd_nx, wr_nx;
   logic [AW:0] cnt;
   logic [W-1:0] head_nx;
   logic do_push, do_pop;

   assign full = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);
   assign do_pop = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_nx = (rd == AW'(DEPTH-1)) ? '0 : rd + 1'b1;
   assign wr_nx = (wr == AW'(DEPTH-1)) ? '0 : wr + 1'b1;

   // next head: new data when it lands in an empty slot, else the following entry
   always_comb begin
      head_nx = dout;
      if (do_push & (empty | (do_pop & cnt == (AW+1)'(1))))
         head_nx = din;
      else if (do_pop & cnt > (AW+1)'(1))
         head_nx = mem[rd_nx];
   end

   // storage write, no reset needed since occupancy is tracked separately
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr] <= din;
   end

   // pointers, occupancy and registered head
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd <= '0;
         wr <= '0;
         cnt <= '0;
         dout <= '0;
      end else begin
         dout <= head_nx;
         if (do_push)
            wr <= wr_nx;
         if (do_pop)
            rd <= rd_nx;
         unique case ({do_push, do_pop})
            2'b10: cnt <= cnt + 1'b1;
            2'b01: cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: rtl/het_mixer_decim.sv
// Mixes ADC samples with the NCO sine and dumps rounded block means
// over 2^k pairs into a small output FIFO.
module het_mixer_decim
   import het_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic clken,
   input  logic [3:0] dec_log2,
   input  logic clear_ovf,
   output logic overflow,
   het_mixer_decim_if.slave bus
);
   localparam int CW = DEC_LOG2_MAX + 1;

   logic accept, first, last;
   logic [3:0] k_in, k_reg, k_cur;
   logic [DEC_LOG2_MAX-1:0] cnt;
   logic [CW-1:0] last_cnt;
   tag_t t1, t2;
   sample_t s1_adc;
   lo_t s1_lo;
   prod_t s2_prod;
   acc_t acc, sum, rnd;
   out_t res;
   logic res_v, full, empty, pop;

   assign accept = clken & bus.adc_valid & bus.lo_valid;
   assign k_in = clamp_k(dec_log2);
   assign first = (cnt == '0);
   assign k_cur = first ? k_in : k_reg;
   assign last_cnt = CW'((1 << k_cur) - 1);
   assign last = ({1'b0, cnt} == last_cnt);

   // block position; k is captured on a block's first pair
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
         k_reg <= '0;
      end else if (accept) begin
         if (first)
            k_reg <= k_in;
         cnt <= last ? '0 : cnt + 1'b1;
      end
   end

   // S1: capture the sample pair with its block tag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         t1 <= '0;
         s1_adc <= '0;
         s1_lo <= '0;
      end else begin
         t1 <= '{v: accept, first: first, last: last, k: k_cur};
         if (accept) begin
            s1_adc <= bus.adc_data;
            s1_lo <= bus.lo_data;
         end
      end
   end

   // S2: signed product
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         t2 <= '0;
         s2_prod <= '0;
      end else begin
         t2 <= t1;
         if (t1.v)
            s2_prod <= prod_t'(s1_adc) * prod_t'(s1_lo);
      end
   end

   assign sum = (t2.first ? acc_t'(0) : acc) + acc_t'(s2_prod);
   assign rnd = (sum + (acc_t'(1) << (t2.k + 4'd5))) >>> (t2.k + 4'd6);

   // S3: integrate, and on the last pair dump the rounded mean
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc <= '0;
         res <= '0;
         res_v <= 1'b0;
      end else begin
         res_v <= t2.v & t2.last;
         if (t2.v) begin
            acc <= sum;
            if (t2.last)
               res <= out_t'(rnd);
         end
      end
   end

   assign pop = bus.out_valid & bus.out_ready;
   assign bus.out_valid = ~empty;

   // sticky drop flag; a new drop beats a clear on the same edge
   always_ff @(posedge clk) begin
      if (!reset_n)
         overflow <= 1'b0;
      else if (res_v & full & ~pop)
         overflow <= 1'b1;
      else if (clear_ovf)
         overflow <= 1'b0;
   end

   het_fifo #(
      .W(OUT_W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk(clk),
      .reset_n(reset_n),
      .push(res_v),
      .din(res),
      .pop(pop),
      .dout(bus.out_data),
      .full(full),
      .empty(empty)
   );
endmodule

// File: tb/tb_het_mixer_decim.sv
// Directed bench for het_mixer_decim: k=0 vector table plus
// hand-built sequences for blocks, overflow, gaps, reset and clamp.
module tb_het_mixer_decim;
   import het_pkg::*;

   typedef struct {
      int adc;
      int lo;
      int exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clken = 1'b0;
   logic clear_ovf = 1'b0;
   logic [3:0] dec_log2 = 4'd0;
   logic overflow;

   het_mixer_decim_if bus();

   het_mixer_decim dut (
      .clk(clk),
      .reset_n(reset_n),
      .clken(clken),
      .dec_log2(dec_log2),
      .clear_ovf(clear_ovf),
      .overflow(overflow),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int out_q[$];
   int stamp_q[$];
   vec_t vec[8];

   always @(posedge clk) cyc <= cyc + 1;

   // record every accepted output with the cycle it was first visible
   always @(negedge clk) begin
      if (bus.out_valid && bus.out_ready) begin
         out_q.push_back(int'(bus.out_data));
         stamp_q.push_back(cyc);
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pair(input int a, input int l);
      clken = 1'b1;
      bus.adc_valid = 1'b1;
      bus.lo_valid = 1'b1;
      bus.adc_data = sample_t'(a);
      bus.lo_data = lo_t'(l);
      tick();
      clken = 1'b0;
      bus.adc_valid = 1'b0;
      bus.lo_valid = 1'b0;
   endtask

   task automatic clr();
      out_q.delete();
      stamp_q.delete();
   endtask

   task automatic out_at(input string name, input int idx, input int exp);
      if (out_q.size() > idx)
         check(name, out_q[idx], exp);
      else
         check({name, " missing"}, out_q.size(), idx + 1);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc4;

      vec[0] = '{-1, 32, 0};
      vec[1] = '{-1, 33, -1};
      vec[2] = '{-8192, -32768, 4194304};
      vec[3] = '{8191, -32768, -4193792};
      vec[4] = '{-8192, 32767, -4194176};
      vec[5] = '{7, 5, 1};
      vec[6] = '{-7, 5, -1};
      vec[7] = '{1000, 16384, 256000};

      bus.adc_valid = 1'b0;
      bus.lo_valid = 1'b0;
      bus.adc_data = '0;
      bus.lo_data = '0;
      bus.out_ready = 1'b1;

      repeat (3) tick();
      check("rst out_valid", bus.out_valid, 0);
      check("rst out_data", bus.out_data, 0);
      check("rst overflow", overflow, 0);
      reset_n = 1'b1;
      tick();

      // k=0 vector table
      dec_log2 = 4'd0;
      for (int i = 0; i < 8; i++) begin
         clr();
         pair(vec[i].adc, vec[i].lo);
         repeat (8) tick();
         check($sformatf("vec%0d count", i), out_q.size(), 1);
         out_at($sformatf("vec%0d data", i), 0, vec[i].exp);
      end

      // DC mix, k=2, back-to-back pairs
      clr();
      dec_log2 = 4'd2;
      acc4 = 0;
      for (int i = 0; i < 12; i++) begin
         pair(1000, 16384);
         if (i == 3)
            acc4 = cyc;
      end
      repeat (10) tick();
      check("dc count", out_q.size(), 3);
      for (int j = 0; j < 3; j++)
         out_at($sformatf("dc data%0d", j), j, 256000);
      if (stamp_q.size() > 0)
         check("dc latency", stamp_q[0] - acc4, 3);
      else
         check("dc latency missing", 0, 1);

      // overflow: 6 results into a 4-deep FIFO with no consumer
      clr();
      dec_log2 = 4'd0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++)
         pair((i + 1) * 10, 64);
      repeat (8) tick();
      check("ovf flag", overflow, 1);
      check("ovf valid", bus.out_valid, 1);
      check("ovf head", bus.out_data, 10);
      check("ovf no pop", out_q.size(), 0);
      bus.out_ready = 1'b1;
      repeat (8) tick();
      check("ovf drain count", out_q.size(), 4);
      for (int j = 0; j < 4; j++)
         out_at($sformatf("ovf drain%0d", j), j, (j + 1) * 10);
      check("ovf valid falls", bus.out_valid, 0);
      check("ovf sticky", overflow, 1);
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      check("ovf cleared", overflow, 0);

      // gaps with clken toggling, k changed 1 -> 3 mid-block
      clr();
      dec_log2 = 4'd1;
      for (int i = 0; i < 10; i++) begin
         pair(100 * (i + 1), 640);
         if (i == 0)
            dec_log2 = 4'd3;
         bus.adc_data = sample_t'(5000);
         bus.lo_data = lo_t'(5000);
         bus.adc_valid = 1'b1;
         bus.lo_valid = (i % 2 == 1);
         clken = (i % 2 == 0);
         tick();
         bus.adc_valid = 1'b0;
         bus.lo_valid = 1'b0;
         clken = 1'b0;
      end
      repeat (10) tick();
      check("gap count", out_q.size(), 2);
      out_at("gap blk2", 0, 1500);
      out_at("gap blk8", 1, 6500);

      // reset in the middle of a block
      clr();
      dec_log2 = 4'd2;
      for (int i = 0; i < 3; i++)
         pair(5000, 5000);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("mid rst valid", bus.out_valid, 0);
      for (int i = 0; i < 4; i++)
         pair(100, 640);
      repeat (10) tick();
      check("mid rst count", out_q.size(), 1);
      out_at("mid rst data", 0, 1000);

      // dec_log2 above the maximum clamps to 8
      clr();
      dec_log2 = 4'd12;
      for (int i = 0; i < 512; i++)
         pair(100, 650);
      repeat (10) tick();
      check("clamp count", out_q.size(), 2);
      out_at("clamp data0", 0, 1016);
      out_at("clamp data1", 1, 1016);
      if (stamp_q.size() > 1)
         check("clamp spacing", stamp_q[1] - stamp_q[0], 256);
      else
         check("clamp spacing missing", stamp_q.size(), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
